pixel_streamer: RTL and testbench
=================================

PIXEL_STREAMER -- requirements
Module: pixel_streamer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 28, meaning pixels per row.
REQ-002 The block SHALL have parameter HEIGHT, default 28, meaning rows per frame.
REQ-003 The block SHALL have parameter DATA_BITS, default 8, meaning bits per pixel.
REQ-004 The block SHALL have port clk, input, 1, clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port wr_en, input, 1, frame-RAM write strobe.
REQ-007 The block SHALL have port wr_addr, input, clog2(WIDTH*HEIGHT), raster write address (row*WIDTH+col).
REQ-008 The block SHALL have port wr_data, input, DATA_BITS, pixel to store.
REQ-009 The block SHALL have port start, input, 1, single-cycle request to stream one frame.
REQ-010 The block SHALL have port stall, input, 1, holds the stream; no pixel is issued in a cycle where stall=1.
REQ-011 The block SHALL have port abort, input, 1, terminates the current frame.
REQ-012 The block SHALL have port out_val, output, 1, data_out valid; drives the downstream line buffer's in_val.
REQ-013 The block SHALL have port data_out, output, DATA_BITS, pixel in raster order.
REQ-014 The block SHALL have ports sof, eol and eof, each an output of width 1, qualifying out_val for first pixel, last pixel of row and last pixel of frame.
REQ-015 The block SHALL have ports busy and done, each an output of width 1: busy is high while a frame is in progress; done pulses when a frame completes.

Function
REQ-016 The block SHALL contain a WIDTH*HEIGHT x DATA_BITS frame RAM with a synchronous write port and a synchronous read port (1-cycle read latency).
REQ-017 A write SHALL occur when wr_en=1, busy=0 and wr_addr<WIDTH*HEIGHT; any other write SHALL be dropped.
REQ-018 The FSM SHALL have states IDLE and STREAM, with IDLE->STREAM on start=1 in IDLE; start in STREAM SHALL be ignored.
REQ-019 In STREAM, each cycle with stall=0 SHALL issue a RAM read at row*WIDTH+col and advance col; col wraps WIDTH-1->0 with row+1.
REQ-020 out_val SHALL be registered: high exactly one cycle after a read issue, with data_out being that address's pixel.
REQ-021 data_out SHALL hold its last value while out_val=0.
REQ-022 sof SHALL be high with out_val for pixel (0,0); eol SHALL be high for col=WIDTH-1; eof SHALL be high for (HEIGHT-1, WIDTH-1); all are 0 when out_val=0.
REQ-023 After the read for (HEIGHT-1, WIDTH-1) issues, the FSM SHALL return to IDLE and reset row/col to 0.
REQ-024 done SHALL be a 1-cycle pulse coincident with the eof beat.
REQ-025 busy SHALL be high from the cycle after start is accepted through the eof beat inclusive.
REQ-026 Latency SHALL be: start at cycle 0 -> first out_val at cycle 2 (no stall); a full frame with no stall SHALL take WIDTH*HEIGHT consecutive out_val cycles.
REQ-027 stall SHALL have priority over pixel issue; stall in IDLE SHALL have no effect.
REQ-028 abort=1 in STREAM SHALL force IDLE next cycle, zero row/col, suppress the pending out_val and any done, and drop busy next cycle.
REQ-029 abort SHALL take priority over stall and over same-cycle start.
REQ-030 A start in the same cycle as the eof beat SHALL be accepted, since the FSM is already in IDLE, giving back-to-back frames with a 1-cycle out_val gap.

Reset
REQ-031 When rst_n=0, the block SHALL force state=IDLE, row=col=0 and out_val=sof=eol=eof=busy=done=0, with data_out=0.
REQ-032 Frame RAM contents SHALL NOT be reset.
REQ-033 Assertion of rst_n mid-frame SHALL terminate the frame with no done.

Verification (WIDTH=4, HEIGHT=3, DATA_BITS=8)
REQ-034 The bench SHALL load addr k with data k+16 for k=0..11, pulse start, hold stall=0 -> 12 consecutive out_val beats with data 16..27, sof on beat 1, eol on beats 4/8/12, eof+done on beat 12.
REQ-035 The bench SHALL hold stall=1 for 3 cycles after beat 5 -> beats 6..12 delayed 3 cycles, data order unchanged, no duplicates or losses.
REQ-036 The bench SHALL pulse abort at beat 7 -> no further out_val, done never pulses, busy=0 next cycle; a new start then streams from 16.
REQ-037 The bench SHALL pulse start in the eof cycle -> second frame's sof arrives 2 cycles later with data 16.
REQ-038 The bench SHALL write addr 3 = 0xAA while busy, then write addr 12 = 0x55 while idle -> both dropped; the next frame's beat 4 reads 19.
REQ-039 The bench SHALL drive rst_n low at beat 6 -> all outputs 0 asynchronously; after release, a new start reproduces the scenario of REQ-034 exactly with the RAM contents intact.

Source files
------------

// File: rtl/pixel_streamer.sv
// Frame streamer: a WIDTH x HEIGHT pixel RAM filled by a write port while idle,
// then read out in raster order with sof/eol/eof qualifiers, stall and abort.
module pixel_streamer #(
  parameter int unsigned WIDTH     = 28,
  parameter int unsigned HEIGHT    = 28,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  wr_en,
  input  logic [$clog2(WIDTH*HEIGHT)-1:0]       wr_addr,
  input  logic [DATA_BITS-1:0]                  wr_data,
  input  logic                                  start,
  input  logic                                  stall,
  input  logic                                  abort,
  output logic                                  out_val,
  output logic [DATA_BITS-1:0]                  data_out,
  output logic                                  sof,
  output logic                                  eol,
  output logic                                  eof,
  output logic                                  busy,
  output logic                                  done
);

  localparam int unsigned DEPTH = WIDTH * HEIGHT;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int unsigned RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [RW-1:0]        row_q, row_d;
  logic [CW-1:0]        col_q, col_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 out_val_q, out_val_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 sof_q, sof_d;
  logic                 eol_q, eol_d;
  logic                 eof_q, eof_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic                 wr_fire;
  logic                 last_col;
  logic                 last_row;

  // Writes are only accepted between frames and for in-range addresses.
  assign wr_fire  = wr_en && !busy_q && (32'(wr_addr) < DEPTH);
  assign last_col = (col_q == CW'(WIDTH - 1));
  assign last_row = (row_q == RW'(HEIGHT - 1));

  // Frame RAM is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    addr_d     = addr_q;
    out_val_d  = 1'b0;
    data_out_d = data_out_q;
    sof_d      = 1'b0;
    eol_d      = 1'b0;
    eof_d      = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          row_d   = '0;
          col_d   = '0;
          addr_d  = '0;
        end
      end
      STREAM: begin
        if (abort) begin
          state_d = IDLE;
          row_d   = '0;
          col_d   = '0;
          addr_d  = '0;
        end else if (!stall) begin
          // Issue one read; its pixel and qualifiers appear next cycle.
          out_val_d  = 1'b1;
          data_out_d = mem[addr_q];
          sof_d      = (addr_q == '0);
          eol_d      = last_col;
          eof_d      = last_col && last_row;
          done_d     = last_col && last_row;
          if (last_col && last_row) begin
            state_d = IDLE;
            row_d   = '0;
            col_d   = '0;
            addr_d  = '0;
          end else if (last_col) begin
            col_d  = '0;
            row_d  = row_q + RW'(1);
            addr_d = addr_q + AW'(1);
          end else begin
            col_d  = col_q + CW'(1);
            addr_d = addr_q + AW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Busy covers the whole frame including the final eof beat.
    busy_d = (state_d == STREAM) || eof_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      addr_q     <= '0;
      out_val_q  <= 1'b0;
      data_out_q <= '0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
      eof_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      addr_q     <= addr_d;
      out_val_q  <= out_val_d;
      data_out_q <= data_out_d;
      sof_q      <= sof_d;
      eol_q      <= eol_d;
      eof_q      <= eof_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign out_val  = out_val_q;
  assign data_out = data_out_q;
  assign sof      = sof_q;
  assign eol      = eol_q;
  assign eof      = eof_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_pixel_streamer.sv
// Bench for pixel_streamer on a 4x3 frame: directed table, corner-case sequences
// and random traffic, all checked against an index-based frame model.
module tb_pixel_streamer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic       stall;
  logic       abort;
  logic       out_val;
  logic [7:0] data_out;
  logic       sof;
  logic       eol;
  logic       eof;
  logic       busy;
  logic       done;

  pixel_streamer #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .stall    (stall),
    .abort    (abort),
    .out_val  (out_val),
    .data_out (data_out),
    .sof      (sof),
    .eol      (eol),
    .eof      (eof),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int beats = 0;
  int done_cnt = 0;
  int eof_cyc  = 0;
  logic [7:0] got [$];

  // Reference model: a frame is a pixel index walking 0..N-1.
  bit         m_stream;
  int         m_idx;
  logic [7:0] m_mem [N];
  bit         e_val, e_sof, e_eol, e_eof, e_busy, e_done;
  logic [7:0] e_data;

  typedef struct {
    logic       start;
    logic       stall;
    logic       abort;
    logic       val;
    logic [7:0] data;
    logic       sof;
    logic       eol;
    logic       eof;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_stream = 1'b0;
    m_idx    = 0;
    e_val    = 1'b0;
    e_sof    = 1'b0;
    e_eol    = 1'b0;
    e_eof    = 1'b0;
    e_busy   = 1'b0;
    e_done   = 1'b0;
    e_data   = 8'h00;
  endtask

  task automatic model_edge();
    bit busy_now;
    if (!rst_n) begin
      model_reset();
    end else begin
      busy_now = e_busy;
      e_val = 1'b0;
      e_sof = 1'b0;
      e_eol = 1'b0;
      e_eof = 1'b0;
      e_done = 1'b0;
      if (!m_stream) begin
        if (start) begin
          m_stream = 1'b1;
          m_idx    = 0;
        end
      end else if (abort) begin
        m_stream = 1'b0;
        m_idx    = 0;
      end else if (!stall) begin
        e_val  = 1'b1;
        e_data = m_mem[m_idx];
        e_sof  = (m_idx == 0);
        e_eol  = (m_idx % W == W - 1);
        e_eof  = (m_idx == N - 1);
        e_done = e_eof;
        m_idx++;
        if (m_idx == N) begin
          m_stream = 1'b0;
          m_idx    = 0;
        end
      end
      e_busy = m_stream || e_eof;
      if (wr_en && !busy_now && int'(wr_addr) < N) m_mem[wr_addr] = wr_data;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    chk("out_val",  32'(out_val),  32'(e_val));
    chk("data_out", 32'(data_out), 32'(e_data));
    chk("sof",      32'(sof),      32'(e_sof));
    chk("eol",      32'(eol),      32'(e_eol));
    chk("eof",      32'(eof),      32'(e_eof));
    chk("busy",     32'(busy),     32'(e_busy));
    chk("done",     32'(done),     32'(e_done));
    if (out_val) begin
      got.push_back(data_out);
      beats++;
      if (eof) eof_cyc = cyc;
    end
    if (done) done_cnt++;
  endtask

  task automatic clear_stats();
    got.delete();
    beats    = 0;
    done_cnt = 0;
  endtask

  task automatic run_until_beats(input int n);
    for (int i = 0; i < 200 && beats < n; i++) step();
    chk("beat_count_reached", 32'(beats), 32'(n));
  endtask

  task automatic run_idle();
    for (int i = 0; i < 200 && busy; i++) step();
    chk("idle_reached", 32'(busy), 32'(0));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_out_val"},  32'(out_val),  32'(0));
    chk({tag, "_data_out"}, 32'(data_out), 32'(0));
    chk({tag, "_sof"},      32'(sof),      32'(0));
    chk({tag, "_eol"},      32'(eol),      32'(0));
    chk({tag, "_eof"},      32'(eof),      32'(0));
    chk({tag, "_busy"},     32'(busy),     32'(0));
    chk({tag, "_done"},     32'(done),     32'(0));
  endtask

  task automatic run_table();
    clear_stats();
    for (int j = 0; j < 14; j++) begin
      start = tbl[j].start;
      stall = tbl[j].stall;
      abort = tbl[j].abort;
      step();
      chk($sformatf("tbl%0d_val", j),  32'(out_val),  32'(tbl[j].val));
      chk($sformatf("tbl%0d_data", j), 32'(data_out), 32'(tbl[j].data));
      chk($sformatf("tbl%0d_sof", j),  32'(sof),      32'(tbl[j].sof));
      chk($sformatf("tbl%0d_eol", j),  32'(eol),      32'(tbl[j].eol));
      chk($sformatf("tbl%0d_eof", j),  32'(eof),      32'(tbl[j].eof));
      chk($sformatf("tbl%0d_busy", j), 32'(busy),     32'(tbl[j].busy));
      chk($sformatf("tbl%0d_done", j), 32'(done),     32'(tbl[j].done));
    end
    start = 1'b0;
  endtask

  initial begin
    int t0;
    int e_at;

    // Entry j: inputs for one cycle, expected outputs on the following cycle.
    for (int j = 0; j < 14; j++) begin
      tbl[j].start = (j == 0);
      tbl[j].stall = 1'b0;
      tbl[j].abort = 1'b0;
      tbl[j].val   = (j >= 1 && j <= N);
      tbl[j].data  = (j == 0) ? 8'd0 : (j <= N) ? 8'(15 + j) : 8'(15 + N);
      tbl[j].sof   = (j == 1);
      tbl[j].eol   = (j >= 1 && j <= N && j % W == 0);
      tbl[j].eof   = (j == N);
      tbl[j].busy  = (j <= N);
      tbl[j].done  = (j == N);
    end

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stall = 1'b0; abort = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Load pixel k with k+16.
    for (int k = 0; k < N; k++) begin
      wr_en = 1'b1; wr_addr = 4'(k); wr_data = 8'(k + 16);
      step();
    end
    wr_en = 1'b0;
    step();

    run_table();
    step();

    // Three stall cycles after beat 5 push beats 6..12 back by three cycles.
    clear_stats();
    start = 1'b1; t0 = cyc; step(); start = 1'b0;
    run_until_beats(5);
    stall = 1'b1; step(); step(); step(); stall = 1'b0;
    run_until_beats(N);
    chk("stall_eof_cycle", 32'(eof_cyc), 32'(t0 + N + 4));
    chk("stall_beat_total", 32'(got.size()), 32'(N));
    for (int i = 0; i < N && i < got.size(); i++) chk($sformatf("stall_order%0d", i), 32'(got[i]), 32'(16 + i));
    run_idle();

    // Abort at beat 7, with stall and start asserted alongside it.
    clear_stats();
    start = 1'b1; step(); start = 1'b0;
    run_until_beats(7);
    abort = 1'b1; stall = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; stall = 1'b0; start = 1'b0;
    chk("abort_busy_drop", 32'(busy), 32'(0));
    chk("abort_no_val", 32'(out_val), 32'(0));
    repeat (6) step();
    chk("abort_total_beats", 32'(beats), 32'(7));
    chk("abort_no_done", 32'(done_cnt), 32'(0));
    clear_stats();
    start = 1'b1; step(); start = 1'b0; step();
    chk("restart_sof", 32'(sof), 32'(1));
    chk("restart_data", 32'(data_out), 32'(16));
    run_idle();

    // Start on the eof beat: next frame's sof two cycles later.
    clear_stats();
    start = 1'b1; step(); start = 1'b0;
    run_until_beats(N);
    e_at = cyc;
    start = 1'b1; step(); start = 1'b0;
    chk("b2b_gap_val", 32'(out_val), 32'(0));
    chk("b2b_gap_busy", 32'(busy), 32'(1));
    step();
    chk("b2b_sof", 32'(sof), 32'(1));
    chk("b2b_data", 32'(data_out), 32'(16));
    chk("b2b_cycle", 32'(cyc), 32'(e_at + 2));
    run_idle();

    // Busy write and out-of-range write are both dropped.
    clear_stats();
    start = 1'b1; step(); start = 1'b0; step();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'hAA; step(); wr_en = 1'b0;
    run_idle();
    wr_en = 1'b1; wr_addr = 4'd12; wr_data = 8'h55; step(); wr_en = 1'b0;
    clear_stats();
    start = 1'b1; step(); start = 1'b0;
    run_until_beats(4);
    chk("drop_beat4", 32'(data_out), 32'(19));
    run_idle();

    // Asynchronous reset at beat 6, then the first frame again.
    clear_stats();
    start = 1'b1; step(); start = 1'b0;
    run_until_beats(6);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("async_rst");
    step(); step();
    #2 rst_n = 1'b1;
    chk("rst_no_done", 32'(done_cnt), 32'(0));
    step();
    run_table();
    step();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      start   = ($urandom % 6 == 0);
      stall   = ($urandom % 3 == 0);
      abort   = ($urandom % 40 == 0);
      wr_en   = ($urandom % 4 == 0);
      wr_addr = 4'($urandom);
      wr_data = 8'($urandom);
      step();
    end
    start = 1'b0; stall = 1'b0; abort = 1'b0; wr_en = 1'b0;
    run_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
